// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and the alignment rule used at request acceptance.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    // Size 2'b11 has no legal alignment, so it always reports as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addrLo[0];
            SZ_WORD: bad = (addrLo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle of the load/store unit.
// The unit sits on the slave modport; the execute stage plus memory use master.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wrt;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wrt
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wrt
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_mux.sv
// Big-endian lane steering: extracts and extends sub-word loads, and merges
// sub-word store data into a previously read word.
module byte_lane_mux
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    // Offset 0 is the most significant byte of the word.
    always_comb begin
        laneByte = word_i[7:0];
        case (offset_i)
            2'd0:    laneByte = word_i[31:24];
            2'd1:    laneByte = word_i[23:16];
            2'd2:    laneByte = word_i[15:8];
            default: laneByte = word_i[7:0];
        endcase
        laneHalf = offset_i[1] ? word_i[15:0] : word_i[31:16];

        extract_o = word_i;
        case (size_i)
            SZ_BYTE: extract_o = {{24{~unsigned_i & laneByte[7]}}, laneByte};
            SZ_HALF: extract_o = {{16{~unsigned_i & laneHalf[15]}}, laneHalf};
            default: extract_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (offset_i)
                    2'd0:    merge_o[31:24] = wdata_i[7:0];
                    2'd1:    merge_o[23:16] = wdata_i[7:0];
                    2'd2:    merge_o[15:8]  = wdata_i[7:0];
                    default: merge_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset_i[1]) merge_o[15:0]  = wdata_i[15:0];
                else             merge_o[31:16] = wdata_i[15:0];
            end
            SZ_WORD: merge_o = wdata_i;
            default: merge_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer for a word-write-only memory;
// sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    state_t            state_q, state_d;
    logic              reqWr_q, reqWr_d;
    logic [1:0]        reqSize_q, reqSize_d;
    logic              reqUnsigned_q, reqUnsigned_d;
    logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
    logic [31:0]       reqWdata_q, reqWdata_d;
    logic [31:0]       respRdata_q, respRdata_d;
    logic              respErr_q, respErr_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [31:0]       memWdata_q, memWdata_d;

    logic        accept;
    logic        reqErr;
    logic [31:0] extractedWord;
    logic [31:0] mergedWord;

    byte_lane_mux u_lane (
        .word_i     (bus.mem_rdata),
        .wdata_i    (reqWdata_q),
        .offset_i   (reqAddr_q[1:0]),
        .size_i     (reqSize_q),
        .unsigned_i (reqUnsigned_q),
        .extract_o  (extractedWord),
        .merge_o    (mergedWord)
    );

    assign accept = bus.req_valid && (state_q == IDLE);
    assign reqErr = is_misaligned(bus.req_size, bus.req_addr[1:0]);

    always_comb begin
        state_d       = state_q;
        reqWr_d       = reqWr_q;
        reqSize_d     = reqSize_q;
        reqUnsigned_d = reqUnsigned_q;
        reqAddr_d     = reqAddr_q;
        reqWdata_d    = reqWdata_q;
        respRdata_d   = respRdata_q;
        respErr_d     = respErr_q;
        memAddr_d     = memAddr_q;
        memWdata_d    = memWdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    reqWr_d       = bus.req_wr;
                    reqSize_d     = bus.req_size;
                    reqUnsigned_d = bus.req_unsigned;
                    reqAddr_d     = bus.req_addr;
                    reqWdata_d    = bus.req_wdata;
                    respRdata_d   = 32'h0;
                    respErr_d     = reqErr;
                    // Memory address is set up here so it is already valid in RD/WR.
                    if (reqErr) begin
                        state_d = RESP;
                    end else if (bus.req_wr && (bus.req_size == SZ_WORD)) begin
                        state_d    = WR;
                        memAddr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        memWdata_d = bus.req_wdata;
                    end else begin
                        state_d   = RD;
                        memAddr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (reqWr_q) begin
                    memWdata_d = mergedWord;
                    state_d    = WR;
                end else begin
                    respRdata_d = extractedWord;
                    state_d     = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            reqWr_q       <= 1'b0;
            reqSize_q     <= SZ_BYTE;
            reqUnsigned_q <= 1'b0;
            reqAddr_q     <= '0;
            reqWdata_q    <= 32'h0;
            respRdata_q   <= 32'h0;
            respErr_q     <= 1'b0;
            memAddr_q     <= '0;
            memWdata_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            reqWr_q       <= reqWr_d;
            reqSize_q     <= reqSize_d;
            reqUnsigned_q <= reqUnsigned_d;
            reqAddr_q     <= reqAddr_d;
            reqWdata_q    <= reqWdata_d;
            respRdata_q   <= respRdata_d;
            respErr_q     <= respErr_d;
            memAddr_q     <= memAddr_d;
            memWdata_q    <= memWdata_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = respRdata_q;
    assign bus.resp_err   = respErr_q;
    assign bus.mem_addr   = memAddr_q;
    assign bus.mem_wdata  = memWdata_q;
    assign bus.mem_wrt    = (state_q == WR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model that
// returns read data one cycle after the address and counts write pulses.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    logic [31:0] memRdata;
    int          wrCount = 0;
    logic [31:0] lastWrAddr = 32'h0;
    logic [31:0] lastWrData = 32'h0;

    assign bus.mem_rdata = memRdata;

    // Registered-read memory; a write is counted on each edge that ends a mem_wrt cycle.
    always @(posedge clk) begin
        memRdata <= mem[bus.mem_addr[7:2]];
        if (bus.mem_wrt) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            wrCount    <= wrCount + 1;
            lastWrAddr <= bus.mem_addr;
            lastWrData <= bus.mem_wdata;
        end
    end

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    // Issues one request from IDLE, waits for its response and checks it.
    task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int expLat, input logic [31:0] expRdata, input logic expErr,
                                 input int expWrites);
        int lat;
        int wrBefore;
        @(negedge clk);
        wrBefore         = wrCount;
        bus.req_wr       = wr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'hFFFF_FFFF;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && expLat > 1) checkOutput({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        end while (!bus.resp_valid && lat < 20);
        checkOutput({tag, "_lat"},    32'(lat), 32'(expLat));
        checkOutput({tag, "_rdata"},  bus.resp_rdata, expRdata);
        checkOutput({tag, "_err"},    32'(bus.resp_err), 32'(expErr));
        checkOutput({tag, "_writes"}, 32'(wrCount - wrBefore), 32'(expWrites));
    endtask

    initial begin
        int wrBefore;
        int pulseCnt;
        int firstAt;
        int secondAt;

        bus.req_valid    = 1'b0;
        bus.req_wr       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(bus.req_ready),  32'd1);
        checkOutput("rst_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_err",   32'(bus.resp_err),   32'd0);
        checkOutput("rst_rdata", bus.resp_rdata,      32'h0);
        checkOutput("rst_maddr", bus.mem_addr,        32'h0);
        checkOutput("rst_wdata", bus.mem_wdata,       32'h0);
        checkOutput("rst_wrt",   32'(bus.mem_wrt),    32'd0);
        rst = 1'b0;

        applyStimulus("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
        checkOutput("sw10_waddr", lastWrAddr, 32'h10);
        checkOutput("sw10_wdata", lastWrData, 32'hDEADBEEF);
        applyStimulus("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);

        applyStimulus("sw_pat", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF017F, 2, 32'h0, 1'b0, 1);
        applyStimulus("lb10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 3, 32'hFFFFFF80, 1'b0, 0);
        applyStimulus("lbu10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 3, 32'h00000080, 1'b0, 0);
        applyStimulus("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 3, 32'h0000007F, 1'b0, 0);
        applyStimulus("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 3, 32'h0000017F, 1'b0, 0);
        applyStimulus("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 3, 32'h000080FF, 1'b0, 0);

        applyStimulus("sw_rmw", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 32'h0, 1'b0, 1);
        applyStimulus("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, 4, 32'h0, 1'b0, 1);
        checkOutput("sb11_waddr", lastWrAddr, 32'h10);
        checkOutput("sb11_wdata", lastWrData, 32'h11AA3344);
        applyStimulus("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFEBEEF, 4, 32'h0, 1'b0, 1);
        checkOutput("sh12_wdata", lastWrData, 32'h11AABEEF);
        applyStimulus("lw_rmw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'h11AABEEF, 1'b0, 0);

        applyStimulus("err_lh13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0);
        applyStimulus("err_sw12", 1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1, 32'h0, 1'b1, 0);
        applyStimulus("err_sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);

        // Abort a byte store in its CAP cycle; the word at 0x20 must survive.
        applyStimulus("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, 2, 32'h0, 1'b0, 1);
        @(negedge clk);
        wrBefore         = wrCount;
        bus.req_wr       = 1'b1;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h20;
        bus.req_wdata    = 32'h000000CC;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_maddr", bus.mem_addr,        32'h0);
        checkOutput("abort_wrt",   32'(bus.mem_wrt),    32'd0);
        checkOutput("abort_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("abort_ready", 32'(bus.req_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_ready_after", 32'(bus.req_ready), 32'd1);
        checkOutput("abort_nowrite", 32'(wrCount - wrBefore), 32'd0);
        applyStimulus("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 32'h55667788, 1'b0, 0);

        // Held request: two loads, responses expected 4 cycles apart.
        @(negedge clk);
        bus.req_wr       = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_valid    = 1'b1;
        pulseCnt = 0;
        firstAt  = 0;
        secondAt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.resp_valid) begin
                pulseCnt++;
                if (pulseCnt == 1) firstAt = i;
                else secondAt = i;
                checkOutput("b2b_rdata", bus.resp_rdata, 32'h11AABEEF);
            end
            if (i == 8) bus.req_valid = 1'b0;
        end
        checkOutput("b2b_pulses", 32'(pulseCnt), 32'd2);
        checkOutput("b2b_first",  32'(firstAt),  32'd3);
        checkOutput("b2b_gap",    32'(secondAt - firstAt), 32'd4);
        repeat (2) @(negedge clk);
        checkOutput("b2b_idle", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
